// File: rtl/tune_player.sv
// Buzzer tune sequencer: plays one of four fixed ROM tunes as a square wave
// on beep, with per-note duration in beats and an optional silent gap.
module tune_player #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] tune_sel,
  input  logic       stop,
  input  logic       mute,
  output logic       beep,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, TONE, GAP} state_t;

  // Pitch codes; 0 and 11..15 are rests.
  localparam logic [3:0] P_REST = 4'd0;
  localparam logic [3:0] P_C4   = 4'd1;
  localparam logic [3:0] P_D4   = 4'd2;
  localparam logic [3:0] P_E4   = 4'd3;
  localparam logic [3:0] P_F4   = 4'd4;
  localparam logic [3:0] P_G4   = 4'd5;
  localparam logic [3:0] P_C5   = 4'd8;
  localparam logic [3:0] P_E5   = 4'd10;

  // Entry layout: {end, beats-1 [1:0], pitch [3:0]}
  localparam logic [6:0] END_ENTRY = 7'b1_00_0000;

  function automatic logic [31:0] half_period(input int unsigned f);
    int unsigned h;
    h = CLK_HZ / (2 * f);
    return (h == 0) ? 32'd1 : h;
  endfunction

  localparam logic [31:0] HP_C4 = half_period(262);
  localparam logic [31:0] HP_D4 = half_period(294);
  localparam logic [31:0] HP_E4 = half_period(330);
  localparam logic [31:0] HP_F4 = half_period(349);
  localparam logic [31:0] HP_G4 = half_period(392);
  localparam logic [31:0] HP_A4 = half_period(440);
  localparam logic [31:0] HP_B4 = half_period(494);
  localparam logic [31:0] HP_C5 = half_period(523);
  localparam logic [31:0] HP_D5 = half_period(587);
  localparam logic [31:0] HP_E5 = half_period(659);

  // Zero half period marks a rest: the phase never toggles.
  function automatic logic [31:0] hp_of(input logic [3:0] p);
    case (p)
      4'd1:    return HP_C4;
      4'd2:    return HP_D4;
      4'd3:    return HP_E4;
      4'd4:    return HP_F4;
      4'd5:    return HP_G4;
      4'd6:    return HP_A4;
      4'd7:    return HP_B4;
      4'd8:    return HP_C5;
      4'd9:    return HP_D5;
      4'd10:   return HP_E5;
      default: return '0;
    endcase
  endfunction

  function automatic logic [6:0] nt(input logic [3:0] p, input logic [1:0] beats_m1);
    return {1'b0, beats_m1, p};
  endfunction

  function automatic logic [6:0] rom_entry(input logic [1:0] t, input logic [3:0] i);
    logic [6:0] e;
    e = END_ENTRY;
    case (t)
      2'd0: case (i)
              4'd0: e = nt(P_C4, 2'd0);
              4'd1: e = nt(P_E4, 2'd0);
              4'd2: e = nt(P_G4, 2'd0);
              4'd3: e = nt(P_C5, 2'd0);
              4'd4: e = nt(P_E4, 2'd0);
              4'd5: e = nt(P_C4, 2'd1);
              default: e = END_ENTRY;
            endcase
      2'd1: case (i)
              4'd0: e = nt(P_E5, 2'd0);
              default: e = END_ENTRY;
            endcase
      2'd2: case (i)
              4'd0: e = nt(P_G4, 2'd0);
              4'd1: e = nt(P_E4, 2'd0);
              4'd2: e = nt(P_C4, 2'd0);
              4'd3: e = nt(P_REST, 2'd0);
              4'd4: e = nt(P_C4, 2'd1);
              default: e = END_ENTRY;
            endcase
      default: case (i)
              4'd0: e = nt(P_C4, 2'd0);
              4'd1: e = nt(P_D4, 2'd0);
              4'd2: e = nt(P_E4, 2'd0);
              4'd3: e = nt(P_F4, 2'd0);
              4'd4: e = nt(P_G4, 2'd0);
              default: e = END_ENTRY;
            endcase
    endcase
    return e;
  endfunction

  state_t      state, state_nx;
  logic [1:0]  tune;
  logic [31:0] half_per, phase_cnt, tone_cnt, gap_cnt, tone_len;
  logic        phase;
  logic        restart, advance;
  logic [6:0]  ent;
  logic        ent_end;
  logic [1:0]  ent_beats;
  logic [3:0]  ent_pitch;

  assign ent       = rom_entry(tune, note_idx);
  assign ent_end   = ent[6];
  assign ent_beats = ent[5:4];
  assign ent_pitch = ent[3:0];
  assign tone_len  = ({30'd0, ent_beats} + 32'd1) * BEAT_CYCLES;
  assign busy      = (state != IDLE);

  // Next-state decode, done pulse and note sequencing strobes.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    restart  = 1'b0;
    advance  = 1'b0;
    if (rst || stop) begin
      state_nx = IDLE;
    end else if (start) begin
      state_nx = LOAD;
      restart  = 1'b1;
    end else begin
      case (state)
        IDLE: state_nx = IDLE;
        LOAD: begin
          if (ent_end) begin
            state_nx = IDLE;
            done     = 1'b1;
          end else begin
            state_nx = TONE;
          end
        end
        TONE, GAP: begin
          if ((state == TONE) ? (tone_cnt <= 32'd1) : (gap_cnt <= 32'd1)) begin
            if (state == TONE && GAP_CYCLES != 0) begin
              state_nx = GAP;
            end else if (note_idx == 4'hF) begin
              // Last ROM slot with no end flag: finish here instead of wrapping.
              state_nx = IDLE;
              done     = 1'b1;
            end else begin
              state_nx = LOAD;
              advance  = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register, note counters, tone phase and registered beep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tune      <= '0;
      note_idx  <= '0;
      half_per  <= '0;
      phase_cnt <= '0;
      tone_cnt  <= '0;
      gap_cnt   <= '0;
      phase     <= 1'b0;
      beep      <= 1'b0;
    end else begin
      state <= state_nx;
      beep  <= 1'b0;
      if (restart) begin
        tune      <= tune_sel;
        note_idx  <= '0;
        phase     <= 1'b0;
        phase_cnt <= '0;
        tone_cnt  <= '0;
        gap_cnt   <= '0;
      end else begin
        if (advance) note_idx <= note_idx + 4'd1;
        case (state)
          LOAD: begin
            half_per  <= hp_of(ent_pitch);
            tone_cnt  <= tone_len;
            phase     <= 1'b0;
            phase_cnt <= '0;
          end
          TONE: begin
            tone_cnt <= tone_cnt - 32'd1;
            // Phase keeps running under mute; mute only masks the output.
            if (state_nx == TONE) begin
              if (half_per != '0 && phase_cnt == half_per - 32'd1) begin
                phase_cnt <= '0;
                phase     <= ~phase;
                beep      <= ~phase & ~mute;
              end else begin
                if (half_per != '0) phase_cnt <= phase_cnt + 32'd1;
                beep <= phase & ~mute;
              end
            end
            if (state_nx == GAP) gap_cnt <= GAP_CYCLES;
          end
          GAP: gap_cnt <= gap_cnt - 32'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/tune_player.md
TUNE_PLAYER -- requirements
Module: tune_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BEAT_CYCLES, default 25_000_000, clock cycles per beat (one duration unit).
REQ-003 SHALL have parameter GAP_CYCLES, default 2_500_000, silent cycles between consecutive notes (0 = legato, no gap).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to play tune_sel.
REQ-007 SHALL have port tune_sel  input  2  tune index sampled when start=1.
REQ-008 SHALL have port stop  input  1  abort current tune.
REQ-009 SHALL have port mute  input  1  force beep low without affecting timing.
REQ-010 SHALL have port beep  output  1  square-wave buzzer drive, registered.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on normal tune completion.
REQ-013 SHALL have port note_idx  output  4  index of the entry currently loaded/playing.

Function
REQ-014 SHALL hold an internal ROM of 4 tunes x 16 entries; entry = pitch (4b), beats (2b, value+1 = 1..4 beats), end flag.
REQ-015 Pitch codes SHALL be: 0 rest, 1 C4 262, 2 D4 294, 3 E4 330, 4 F4 349, 5 G4 392, 6 A4 440, 7 B4 494, 8 C5 523, 9 D5 587, 10 E5 659 Hz; 11-15 treated as rest.
REQ-016 Half period SHALL be floor(CLK_HZ/(2*f)) computed at elaboration, clamped to minimum 1; counters 32 bits.
REQ-017 Tune 0 (victory) SHALL be C4,E4,G4,C5,E4 one beat each, C4 two beats, end.
REQ-018 Tune 1 (push) SHALL be E5 one beat, end; tune 2 (fail) G4,E4,C4 one beat, rest one beat, C4 two beats, end; tune 3 (level start) C4,D4,E4,F4,G4 one beat each, end.
REQ-019 States SHALL be IDLE, LOAD, TONE, GAP.
REQ-020 IDLE: beep=0, busy=0; start=1 -> latch tune_sel, note_idx=0, go LOAD next cycle.
REQ-021 LOAD (one cycle): read entry; end flag -> assert done for that cycle, go IDLE; else load half period and tone length (beats*BEAT_CYCLES), go TONE.
REQ-022 TONE: lasts exactly beats*BEAT_CYCLES cycles; beep starts 0 at entry and toggles after every half-period cycles; rest pitch keeps beep=0.
REQ-023 TONE end: go GAP if GAP_CYCLES>0, else LOAD with note_idx+1; beep SHALL be 0 in the first cycle after TONE.
REQ-024 GAP: beep=0 for GAP_CYCLES cycles, then LOAD with note_idx+1.
REQ-025 Entry 15 without end flag SHALL be treated as end after it plays (done pulse, IDLE); note_idx never wraps to 0 during play.
REQ-026 start while busy SHALL preempt: latch new tune_sel, note_idx=0, go LOAD next cycle, beep=0, no done for the aborted tune.
REQ-027 stop (any non-IDLE state) SHALL go IDLE next cycle with beep=0 and no done; stop and start in the same cycle: stop wins.
REQ-028 mute=1 SHALL force beep=0 while internal phase and timing advance unchanged; deasserting mute resumes the current phase.

Reset
REQ-029 rst=1 SHALL force IDLE, beep=0, busy=0, done=0, note_idx=0, all counters 0, regardless of state and of start/stop.
REQ-030 rst SHALL take priority over start, stop, and mute in the same cycle.

Verification (CLK_HZ=100_000, BEAT_CYCLES=1000, GAP_CYCLES=100)
REQ-031 Start tune 1 -> busy next cycle; beep period 2*75 cycles for 1000 cycles; done pulse 1 cycle after the 100-cycle gap plus LOAD; busy low after done.
REQ-032 Start tune 0 -> half periods 190,151,127,95,151,190 in order; last note 2000 cycles; exactly one done pulse; total busy = 7000+600+7 LOAD cycles.
REQ-033 Tune 2 -> rest entry yields beep=0 for 1000 cycles while note_idx=3.
REQ-034 Start tune 0, then start tune 3 during note 2 -> note_idx returns to 0, C4/D4 sequence follows, no done for tune 0.
REQ-035 stop mid-TONE -> beep=0 and busy=0 next cycle, no done; mute during tone -> beep 0, total duration unchanged.
REQ-036 rst asserted mid-tune with start=1 in the same cycle -> all outputs 0 and IDLE next cycle.
